// File: rtl/hex_rotate_pkg.sv
// Shared types and constants for the character-rotate sequencer.
package hex_rotate_pkg;

    localparam int CHAR_W   = 2;
    localparam int NUM_CHAR = 4;
    localparam int SEL_W    = 2;
    localparam int WORD_W   = CHAR_W * NUM_CHAR;

    // Reset char word {c3,c2,c1,c0} = 00,01,10,11
    localparam logic [WORD_W-1:0] INIT_WORD_DEF = 8'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_LOAD = 2'd3
    } state_t;

    // Next select value; the 2-bit width gives the modulo-4 wrap for free.
    function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] cur,
                                                   input logic            down);
        return down ? cur - 1'b1 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/hex_rotate_ctrl_prescaler.sv
// Free-running divide-by-TICK_DIV counter with clear and freeze.
// tc is high for the single enabled cycle where the count reads TICK_DIV-1.
module tick_prescaler #(
    parameter int CNT_W    = 26,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_en,
    input  logic cnt_clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = cnt_en && !cnt_clr && (cnt == LAST);

    // Clear wins over count; with neither asserted the count holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hex_rotate_ctrl.sv
// Sequencer for the 4:1 character-select display path. Owns the select and
// char word registers, rotates the select on a timed tick, and accepts new
// char words through a valid/ready load while rotation is stopped.
module hex_rotate_ctrl
    import hex_rotate_pkg::*;
#(
    parameter int                TICK_DIV  = 50_000_000,
    parameter int                CNT_W     = 26,
    parameter logic [WORD_W-1:0] INIT_WORD = INIT_WORD_DEF
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              en,
    input  logic              step,
    input  logic              dir,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [SEL_W-1:0]  sel,
    output logic [WORD_W-1:0] char_word,
    output logic              adv,
    output logic [1:0]        state
);

    state_t            st;
    logic [WORD_W-1:0] ld_buf;
    logic              tc;
    logic              hs;

    assign hs    = ld_valid && ld_ready;
    assign state = st;

    // Counting only happens in RUN; IDLE and LOAD hold it at zero, HOLD freezes it.
    tick_prescaler #(
        .CNT_W    (CNT_W),
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .cnt_en  (st == S_RUN),
        .cnt_clr ((st == S_IDLE) || (st == S_LOAD)),
        .tc      (tc)
    );

    // Control FSM with registered sel/char_word/adv/ld_ready.
    // ld_ready tracks the state it is entering so it is 1 exactly in IDLE/HOLD.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            st        <= S_IDLE;
            sel       <= '0;
            char_word <= INIT_WORD;
            ld_buf    <= INIT_WORD;
            adv       <= 1'b0;
            ld_ready  <= 1'b1;
        end else begin
            adv <= 1'b0;
            case (st)
                S_IDLE, S_HOLD: begin
                    if (hs) begin
                        // Load beats both en and step; the step is dropped.
                        ld_buf   <= ld_data;
                        st       <= S_LOAD;
                        ld_ready <= 1'b0;
                    end else begin
                        if (step) begin
                            sel <= sel_next(sel, dir);
                            adv <= 1'b1;
                        end
                        if (en) begin
                            st       <= S_RUN;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // A terminal count still advances even if en drops that cycle.
                    if (tc) begin
                        sel <= sel_next(sel, dir);
                        adv <= 1'b1;
                    end
                    if (!en) begin
                        st       <= S_HOLD;
                        ld_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    char_word <= ld_buf;
                    sel       <= '0;
                    st        <= S_IDLE;
                    ld_ready  <= 1'b1;
                end
                default: begin
                    st       <= S_IDLE;
                    ld_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_rotate_ctrl.sv
// Directed bench for hex_rotate_ctrl with a 4-clock step period.
module tb_hex_rotate_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       en       = 1'b0;
    logic       step     = 1'b0;
    logic       dir      = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data  = 8'h00;
    logic       ld_ready;
    logic [1:0] sel;
    logic [7:0] char_word;
    logic       adv;
    logic [1:0] state;

    int nvec = 0;
    int nerr = 0;
    int n;

    hex_rotate_ctrl #(
        .TICK_DIV (4),
        .CNT_W    (3)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .en        (en),
        .step      (step),
        .dir       (dir),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .sel       (sel),
        .char_word (char_word),
        .adv       (adv),
        .state     (state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Clocks until adv is seen; returns the bound (50) on timeout.
    task automatic wait_adv(output int cnt);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            cnt++;
            if (adv === 1'b1) break;
        end
    endtask

    initial begin
        // Reset values
        tick();
        chk("rst_state", state, 0);
        chk("rst_sel", sel, 0);
        chk("rst_word", char_word, 8'h1B);
        chk("rst_adv", adv, 0);
        chk("rst_ready", ld_ready, 1);
        RESET_N = 1'b1;

        // 1. forward rotation at 4-clock spacing
        tick();
        chk("t1_idle", state, 0);
        en = 1'b1;
        tick();
        chk("t1_run", state, 1);
        chk("t1_ready_run", ld_ready, 0);
        wait_adv(n); chk("t1_gap1", n, 4); chk("t1_sel1", sel, 1);
        wait_adv(n); chk("t1_gap2", n, 4); chk("t1_sel2", sel, 2);
        wait_adv(n); chk("t1_gap3", n, 4); chk("t1_sel3", sel, 3);
        wait_adv(n); chk("t1_gap4", n, 4); chk("t1_wrap", sel, 0);
        chk("t1_word", char_word, 8'h1B);

        // 2. reverse rotation, hold mid-count, resume from frozen count
        dir = 1'b1;
        wait_adv(n); chk("t2_gap1", n, 4); chk("t2_wrap", sel, 3);
        wait_adv(n); chk("t2_gap2", n, 4); chk("t2_sel2", sel, 2);
        tick();
        en = 1'b0;
        tick();
        chk("t2_hold", state, 2);
        chk("t2_ready_hold", ld_ready, 1);
        tick(); tick();
        chk("t2_hold_sel", sel, 2);
        chk("t2_hold_adv", adv, 0);
        en = 1'b1;
        wait_adv(n); chk("t2_resume_gap", n, 3); chk("t2_resume_sel", sel, 1);
        en = 1'b0;
        tick();
        chk("t2_hold2", state, 2);
        dir = 1'b0;

        // 3. single steps in HOLD, step ignored in RUN
        step = 1'b1; tick(); chk("t3_s1_sel", sel, 2); chk("t3_s1_adv", adv, 1);
        step = 1'b0; tick(); chk("t3_s1_off", adv, 0);
        step = 1'b1; tick(); chk("t3_s2_sel", sel, 3); chk("t3_s2_adv", adv, 1);
        step = 1'b0; tick(); chk("t3_s2_off", adv, 0);
        step = 1'b1; tick(); chk("t3_s3_sel", sel, 0); chk("t3_s3_adv", adv, 1);
        step = 1'b0; tick(); chk("t3_s3_off", adv, 0);
        en = 1'b1;
        tick();
        chk("t3_run", state, 1);
        step = 1'b1; tick();
        chk("t3_run_step_sel", sel, 0);
        chk("t3_run_step_adv", adv, 0);
        step = 1'b0; en = 1'b0;
        tick();
        chk("t3_hold", state, 2);

        // 4. load from HOLD
        ld_valid = 1'b1; ld_data = 8'hE4;
        #1 chk("t4_ready", ld_ready, 1);
        tick();
        chk("t4_load", state, 3);
        chk("t4_load_ready", ld_ready, 0);
        chk("t4_load_word", char_word, 8'h1B);
        ld_valid = 1'b0;
        tick();
        chk("t4_idle", state, 0);
        chk("t4_word", char_word, 8'hE4);
        chk("t4_sel", sel, 0);
        chk("t4_adv", adv, 0);
        chk("t4_ready_idle", ld_ready, 1);

        // 5. load waits through RUN, then wins over a same-cycle step
        en = 1'b1;
        tick();
        ld_valid = 1'b1; ld_data = 8'h39;
        wait_adv(n); chk("t5_gap", n, 4); chk("t5_sel", sel, 1);
        chk("t5_ready_run", ld_ready, 0);
        chk("t5_no_capture", char_word, 8'hE4);
        en = 1'b0;
        tick();
        chk("t5_hold", state, 2);
        chk("t5_ready_hold", ld_ready, 1);
        step = 1'b1;
        tick();
        chk("t5_load", state, 3);
        chk("t5_step_drop_sel", sel, 1);
        chk("t5_step_drop_adv", adv, 0);
        step = 1'b0; ld_valid = 1'b0;
        tick();
        chk("t5_idle", state, 0);
        chk("t5_word", char_word, 8'h39);
        chk("t5_sel0", sel, 0);

        // 6a. async reset mid-LOAD discards the pending word
        ld_valid = 1'b1; ld_data = 8'hAA;
        tick();
        chk("t6_load", state, 3);
        #2 RESET_N = 1'b0;
        #1;
        chk("t6a_state", state, 0);
        chk("t6a_word", char_word, 8'h1B);
        chk("t6a_sel", sel, 0);
        chk("t6a_ready", ld_ready, 1);
        ld_valid = 1'b0;
        #1 RESET_N = 1'b1;
        tick();
        chk("t6a_discard", char_word, 8'h1B);
        chk("t6a_idle", state, 0);

        // 6b. async reset mid-rotation, on an advance cycle
        en = 1'b1;
        tick();
        wait_adv(n); chk("t6b_gap", n, 4); chk("t6b_sel", sel, 1);
        #2 RESET_N = 1'b0;
        #1;
        chk("t6b_adv", adv, 0);
        chk("t6b_sel0", sel, 0);
        chk("t6b_state", state, 0);
        chk("t6b_ready", ld_ready, 1);
        #1 RESET_N = 1'b1;
        tick();
        chk("t6b_run", state, 1);
        wait_adv(n); chk("t6b_regap", n, 4); chk("t6b_resel", sel, 1);

        // en falls on the terminal-count cycle: advance still lands, then HOLD
        tick(); tick(); tick();
        en = 1'b0;
        tick();
        chk("tc_fall_sel", sel, 2);
        chk("tc_fall_adv", adv, 1);
        chk("tc_fall_state", state, 2);
        tick();
        chk("tc_fall_adv_off", adv, 0);
        chk("tc_fall_hold_sel", sel, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
